timer_counter: RTL and testbench
================================

Name: timer_counter

Overview:
- Memory-mapped countdown timer on the CPU bridge bus.
- Drives one HWInt line into the coprocessor-0 interrupt logic; it is the interrupt source that CP0 consumes.
- Software programs it through sw/lw to three word registers.
- Two modes: one-shot with a held interrupt, and auto-reload with a one-cycle interrupt pulse.

Parameters:
- PRESCALE, 4: clock cycles per count decrement. Used only when TIMER_PRESCALE_EN is defined; legal range is 1 or greater.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- addr  in  2  word select (bus address bits [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
- we  in  1  write enable for the addressed register
- din  in  32  write data
- dout  out  32  combinational read data for addr
- irq  out  1  interrupt request to one CP0 HWInt bit

Behaviour:
- Registers:
  - CTRL[3]=IM (interrupt mask), CTRL[2:1]=Mode, CTRL[0]=Enable. CTRL reads as {28'b0,IM,Mode,Enable}; din[31:4] is ignored.
  - PRESET is a full 32-bit read/write register.
  - COUNT is read-only; writes to it are ignored.
  - addr=3 reads 0; writes to it are ignored.
- Mode encoding: 00 = one-shot. 01 = auto-reload. 10 and 11 behave as 00.
- Reset: CTRL, PRESET, COUNT, pending and state all go to 0/IDLE. irq=0 and dout reflects the zeroed registers. Reset overrides everything, including mid-count.
- Internal flag: pending. Output equation: irq = IM & pending.
- FSM, evaluated with the pre-write CTRL value in each cycle:
  - IDLE: if Enable, go to LOAD.
  - LOAD: COUNT<=PRESET; go to CNT.
  - CNT:
    - If !Enable, go to IDLE with COUNT held.
    - Else if COUNT<=1: COUNT<=0, pending<=1, go to INT.
    - Else COUNT<=COUNT-1.
  - INT, one cycle:
    - Mode 01: pending<=0, go to LOAD.
    - Otherwise: Enable<=0, pending held, go to IDLE.
- Latency:
  - Measured from the clock edge that writes Enable=1. With PRESET>=1, pending rises after PRESET+2 edges. With PRESET=0, it rises after 3 edges.
  - Auto-reload period is PRESET+2 cycles, with irq high for exactly 1 cycle per period.
- Pending clear: any bus write to CTRL or PRESET clears pending. If the set (CNT terminal) and a clear occur in the same cycle, the set wins.
- Writes during CNT:
  - A PRESET write takes effect at the next LOAD only; the current COUNT is not disturbed.
  - A CTRL write with Enable=0 stops the count on the following edge.
- IM=0 masks irq but pending still records the event. Setting IM later asserts irq immediately if pending=1.
- Subtraction is 32-bit unsigned; COUNT never wraps below 0.

Optional Feature:
- TIMER_PRESCALE_EN defined:
  - An internal prescale counter, sized to hold PRESCALE-1, is cleared in LOAD.
  - In CNT the counter increments each cycle. The COUNT decrement and terminal check happen only on cycles where it equals PRESCALE-1; it wraps to 0 on those cycles.
  - The Enable=0 exit is still checked every cycle.
  - Latency for PRESET>=1 becomes PRESET*PRESCALE+2 edges.
- Macro undefined: no prescale counter; decrement every CNT cycle, exactly as above.
- The test plan assumes the macro is undefined.

Test Plan:
- Reset, then read all addresses:
  - CTRL, PRESET, COUNT and addr 3 all read 0; irq=0.
  - Assert reset while in CNT with COUNT=7: the next cycle shows COUNT=0, state IDLE, irq=0.
- One-shot:
  - PRESET=3, then CTRL=0x9 (IM=1, mode 00, Enable=1).
  - irq rises exactly 5 edges after the CTRL write and stays high.
  - CTRL reads 0x8 afterwards; COUNT reads 0.
  - Writing CTRL=0x8 drops irq on the next cycle.
- Auto-reload:
  - PRESET=2, CTRL=0xB.
  - irq is high for 1 cycle at edges 4, 8, 12 after the write (period 4).
  - COUNT sequence observed is 2,1,0.
- Masking:
  - One-shot with IM=0 and PRESET=1: irq stays 0 and pending is set.
  - A later CTRL write of IM=1 clears pending, so irq stays 0. Check that the write clear is observed.
- Disable mid-count:
  - PRESET=10, Enable=1; write CTRL=0x8 while COUNT=6.
  - COUNT freezes at 5 (one further decrement in the write cycle, since the FSM uses pre-write CTRL) and irq never asserts.
  - Re-enabling reloads 10.
- Simultaneous events:
  - A PRESET write in the same cycle as the CNT terminal gives pending=1 (set wins) and irq high.
  - With PRESET=0 and Enable, irq asserts 3 edges after the write.

Source files
------------

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes driving a CP0 HWInt line.
// Define TIMER_PRESCALE_EN to slow the count by PRESCALE clock cycles per decrement.
module timer_counter #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    localparam logic [1:0] AddrCtrl   = 2'd0;
    localparam logic [1:0] AddrPreset = 2'd1;
    localparam logic [1:0] AddrCount  = 2'd2;

    typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

    state_e      state_q;
    logic        im_q;
    logic [1:0]  mode_q;
    logic        enable_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        pending_q;

    logic ctrl_wr;
    logic preset_wr;
    logic tick;

    assign ctrl_wr   = we && (addr == AddrCtrl);
    assign preset_wr = we && (addr == AddrPreset);

`ifdef TIMER_PRESCALE_EN
    localparam int unsigned    PsW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

    logic [PsW-1:0] ps_q;

    assign tick = (ps_q == PsLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            ps_q <= '0;
        end else if (state_q == StLoad) begin
            ps_q <= '0;
        end else if (state_q == StCnt && enable_q) begin
            ps_q <= tick ? '0 : ps_q + PsW'(1);
        end
    end
`else
    // Always true for any legal PRESCALE: decrement on every CNT cycle.
    assign tick = (PRESCALE != 0);
`endif

    // Bus writes are applied first; later FSM assignments override them, so a terminal set
    // of pending beats a same-cycle write clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            im_q      <= 1'b0;
            mode_q    <= 2'b00;
            enable_q  <= 1'b0;
            preset_q  <= 32'd0;
            count_q   <= 32'd0;
            pending_q <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                im_q      <= din[3];
                mode_q    <= din[2:1];
                enable_q  <= din[0];
                pending_q <= 1'b0;
            end
            if (preset_wr) begin
                preset_q  <= din;
                pending_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (enable_q) state_q <= StLoad;
                end
                StLoad: begin
                    count_q <= preset_q;
                    state_q <= StCnt;
                end
                StCnt: begin
                    if (!enable_q) begin
                        state_q <= StIdle;
                    end else if (tick) begin
                        if (count_q <= 32'd1) begin
                            count_q   <= 32'd0;
                            pending_q <= 1'b1;
                            state_q   <= StInt;
                        end else begin
                            count_q <= count_q - 32'd1;
                        end
                    end
                end
                StInt: begin
                    if (mode_q == 2'b01) begin
                        pending_q <= 1'b0;
                        state_q   <= StLoad;
                    end else begin
                        // A software CTRL write in the same cycle keeps its Enable value.
                        if (!ctrl_wr) enable_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        dout = 32'd0;
        case (addr)
            AddrCtrl:   dout = {28'd0, im_q, mode_q, enable_q};
            AddrPreset: dout = preset_q;
            AddrCount:  dout = count_q;
            default:    dout = 32'd0;
        endcase
    end

    assign irq = im_q & pending_q;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: register table plus cycle-accurate mode sequences.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int errors = 0;
    int checks = 0;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] din;
        logic [1:0]  raddr;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        we    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        din  = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(name, dout, exp);
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        addr  = 2'd0;
        we    = 1'b0;
        din   = 32'd0;

        // {we, addr, din, read addr, expected dout, expected irq}
        vecs[0]  = '{1'b0, 2'd0, 32'h0,        2'd0, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 2'd0, 32'h0,        2'd1, 32'h0,        1'b0};
        vecs[2]  = '{1'b0, 2'd0, 32'h0,        2'd2, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 2'd0, 32'h0,        2'd3, 32'h0,        1'b0};
        vecs[4]  = '{1'b1, 2'd1, 32'hDEADBEEF, 2'd1, 32'hDEADBEEF, 1'b0};
        vecs[5]  = '{1'b1, 2'd0, 32'hFFFFFFF6, 2'd0, 32'h6,        1'b0};
        vecs[6]  = '{1'b1, 2'd2, 32'h00001234, 2'd2, 32'h0,        1'b0};
        vecs[7]  = '{1'b1, 2'd3, 32'h00000055, 2'd3, 32'h0,        1'b0};
        vecs[8]  = '{1'b0, 2'd0, 32'h0,        2'd1, 32'hDEADBEEF, 1'b0};
        vecs[9]  = '{1'b1, 2'd0, 32'h00000000, 2'd0, 32'h0,        1'b0};
        vecs[10] = '{1'b1, 2'd1, 32'h80000001, 2'd1, 32'h80000001, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            addr = vecs[i].addr;
            din  = vecs[i].din;
            we   = vecs[i].we;
            edge1();
            we   = 1'b0;
            addr = vecs[i].raddr;
            #1;
            chk($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
            chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
        end

        // One-shot: irq rises 5 edges after the enabling write and holds.
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 7; k++) begin
            edge1();
            chk($sformatf("oneshot_irq_e%0d", k), {31'd0, irq}, (k >= 5) ? 32'd1 : 32'd0);
        end
        rd("oneshot_ctrl", 2'd0, 32'h8);
        rd("oneshot_count", 2'd2, 32'd0);
        wr(2'd0, 32'h8);
        chk("oneshot_clear_irq", {31'd0, irq}, 32'd0);

        // Auto-reload: period 4, one-cycle pulse, COUNT cycles 0,2,1,0.
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        addr = 2'd2;
        for (int k = 1; k <= 13; k++) begin
            edge1();
            chk($sformatf("reload_irq_e%0d", k), {31'd0, irq}, (k % 4 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("reload_cnt_e%0d", k), dout,
                (k % 4 == 2) ? 32'd2 : ((k % 4 == 3) ? 32'd1 : 32'd0));
        end

        // Masked one-shot: event recorded in pending, irq held low; CTRL write clears it.
        do_reset();
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 5; k++) begin
            edge1();
            chk($sformatf("mask_irq_e%0d", k), {31'd0, irq}, 32'd0);
        end
        chk("mask_pending_set", {31'd0, dut.pending_q}, 32'd1);
        wr(2'd0, 32'h8);
        chk("mask_pending_clr", {31'd0, dut.pending_q}, 32'd0);
        chk("mask_irq_after_im", {31'd0, irq}, 32'd0);
        edge1();
        chk("mask_irq_later", {31'd0, irq}, 32'd0);

        // Disable mid-count: write at COUNT=6 still decrements once, then freezes at 5.
        do_reset();
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        repeat (6) edge1();
        rd("dis_count6", 2'd2, 32'd6);
        wr(2'd0, 32'h8);
        rd("dis_count5", 2'd2, 32'd5);
        for (int k = 1; k <= 3; k++) begin
            edge1();
            chk($sformatf("dis_hold_e%0d", k), dout, 32'd5);
            chk($sformatf("dis_irq_e%0d", k), {31'd0, irq}, 32'd0);
        end
        wr(2'd0, 32'h9);
        addr = 2'd2;
        repeat (2) edge1();
        chk("reen_reload", dout, 32'd10);

        // Reset mid-count with COUNT=7.
        repeat (3) edge1();
        chk("rst_pre_count7", dout, 32'd7);
        do_reset();
        rd("rst_count", 2'd2, 32'd0);
        rd("rst_ctrl", 2'd0, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'd0);

        // PRESET write coinciding with the terminal cycle: set wins.
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        repeat (3) edge1();
        wr(2'd1, 32'd5);
        chk("simul_irq", {31'd0, irq}, 32'd1);
        edge1();
        chk("simul_irq_hold", {31'd0, irq}, 32'd1);
        rd("simul_ctrl", 2'd0, 32'h8);
        rd("simul_preset", 2'd1, 32'd5);

        // PRESET=0: irq after 3 edges.
        do_reset();
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 4; k++) begin
            edge1();
            chk($sformatf("zero_irq_e%0d", k), {31'd0, irq}, (k >= 3) ? 32'd1 : 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
